// File: rtl/fft_input_loader.sv
// fft_input_loader: streams packed complex FP4 samples into the filling bank of the FFT ping-pong memory.
// Latency: writes are combinational with the accepted sample; start follows the 32nd write by two cycles.
// Backpressure: s_ready drops while padding a short frame and while a full bank waits for the core to release its bank.
//
// Optional feature macro: FFT_LOADER_BITREV_EN
//   defined   -> wr_addr = bitrev5(cnt), so the core can run in-place DIT on natural-order reads
//   undefined -> wr_addr = cnt, natural order (the core does its own reordering)
//
// Bank ownership: the core reads bank bank_sel, the loader fills !bank_sel. A bank is
// handed over only once it is completely written (real samples plus zero padding) and
// the core has released the bank it is currently working on.

module fft_input_loader #(
  parameter int N = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       bank_sel,
  output logic       start,
  input  logic       core_done,
  output logic       short_frame
);

  // Index of the final slot of a frame; the address width is fixed at 5 bits.
  localparam logic [4:0] LAST_SLOT = 5'(N - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] cnt;
  logic       core_owned;

  logic       xfer;
  logic       last_slot;
  logic       swap;
  logic [4:0] addr_map;

`ifdef FFT_LOADER_BITREV_EN
  // Reverse the five address bits so natural-order input lands in DIT order.
  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) begin
      r[i] = a[4-i];
    end
    return r;
  endfunction
`endif

  // Handshake and frame-boundary decode shared by the write path and the FSM.
  assign s_ready   = !rst && (state == FILL);
  assign xfer      = s_valid && s_ready;
  assign last_slot = (cnt == LAST_SLOT);
  assign swap      = (state == FULL) && (!core_owned || core_done);

  // Slot-to-address mapping selected at build time.
  always_comb begin
`ifdef FFT_LOADER_BITREV_EN
    addr_map = bitrev5(cnt);
`else
    addr_map = cnt;
`endif
  end

  // Write port: real samples during FILL, zeros during PAD, idle otherwise; the
  // memory captures on the same edge as the handshake.
  always_comb begin
    wr_en       = 1'b0;
    wr_addr     = 5'd0;
    wr_data     = 8'h00;
    short_frame = 1'b0;
    if (!rst) begin
      wr_addr = addr_map;
      if (xfer) begin
        wr_en   = 1'b1;
        wr_data = s_data;
      end else if (state == PAD) begin
        wr_en       = 1'b1;
        wr_data     = 8'h00;
        // Flag the padded frame on the write that completes it.
        short_frame = last_slot;
      end
    end
  end

  // Frame FSM, slot counter, bank ownership and the registered start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      cnt        <= 5'd0;
      core_owned <= 1'b0;
      bank_sel   <= 1'b0;
      start      <= 1'b0;
    end else begin
      start <= 1'b0;
      // A release from the core frees its bank regardless of loader state; a
      // release while the core owns nothing is harmless.
      if (core_done) begin
        core_owned <= 1'b0;
      end
      case (state)
        FILL: begin
          if (xfer) begin
            cnt <= cnt + 5'd1;
            if (last_slot) begin
              // s_last on the 32nd sample is the normal end of a frame.
              state <= FULL;
            end else if (s_last) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          cnt <= cnt + 5'd1;
          if (last_slot) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (swap) begin
            bank_sel   <= ~bank_sel;
            start      <= 1'b1;
            core_owned <= 1'b1;
            cnt        <= 5'd0;
            state      <= FILL;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule
